// File: rtl/serial_mag_comp_ctrl_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package cmp_pkg;

  // Controller states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  // Result encoding {gtr, eq, lt}
  typedef logic [2:0] res_t;

  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_GT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_LT   = 3'b001;

  // Number of 2-bit slices in a WIDTH-bit operand
  function automatic int nslice(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/serial_mag_comp_ctrl_if.sv
// Handshake and operand/result bus between an operand producer and the comparator.
interface serial_mag_comp_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gtr;
  logic             eq;
  logic             lt;

  modport master (
    output en, start, a, b,
    input  busy, done, gtr, eq, lt
  );

  modport slave (
    input  en, start, a, b,
    output busy, done, gtr, eq, lt
  );

endinterface

// File: rtl/serial_mag_comp_ctrl_slice.sv
// Combinational 2-bit unsigned magnitude compare.
module two_bit_cmp_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       g,
  output logic       e,
  output logic       l
);

  assign g = (x > y);
  assign e = (x == y);
  assign l = (x < y);

endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// Serial magnitude comparator: walks one 2-bit compare slice across two
// latched operands, MSB slice first, and reports A>B, A==B or A<B.
module serial_mag_comp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  serial_mag_comp_ctrl_if.slave bus
);

  localparam int NSLICE = nslice(WIDTH);
  // A single-slice operand still needs a 1-bit index register
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             done_q, done_n;
  res_t             res_q, res_n;
  res_t             first_q, first_n;
  logic             load;

  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       x_sl, y_sl;
  logic             g, e, l;
  res_t             slice_res;

  // Operand mux: pick the slice currently addressed by idx
  assign x_sl      = 2'(a_q >> {idx, 1'b0});
  assign y_sl      = 2'(b_q >> {idx, 1'b0});
  assign slice_res = {g, e, l};

  two_bit_cmp_slice u_slice (
    .x (x_sl),
    .y (y_sl),
    .g (g),
    .e (e),
    .l (l)
  );

  // Control state: FSM, slice index, done pulse and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      done_q <= 1'b0;
      res_q  <= RES_NONE;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      done_q <= done_n;
      res_q  <= res_n;
    end
  end

  // Operand and first-difference registers; always reloaded on start, so no reset
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
    first_q <= first_n;
  end

  // Next-state logic; en=0 leaves every register at its current value
  always_comb begin
    state_n = state;
    idx_n   = idx;
    done_n  = done_q;
    res_n   = res_q;
    first_n = first_q;
    load    = 1'b0;
    if (bus.en) begin
      done_n = 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            load    = 1'b1;
            idx_n   = IDX_TOP;
            first_n = RES_EQ;
            state_n = ST_CMP;
          end
        end
        ST_CMP: begin
          // Remember the most significant difference seen so far
          if (!e && (first_q == RES_EQ)) begin
            first_n = slice_res;
          end
          if (!e && EARLY_EXIT) begin
            res_n   = slice_res;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else if (idx == '0) begin
            res_n   = (first_q == RES_EQ) ? slice_res : first_q;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            idx_n = idx - 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == ST_CMP);
  assign bus.done = done_q;
  assign bus.gtr  = res_q[2];
  assign bus.eq   = res_q[1];
  assign bus.lt   = res_q[0];

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Bench for serial_mag_comp_ctrl: one early-exit and one full-scan instance
// share the same stimulus; a cycle-level reference model tracks both.
module tb_serial_mag_comp_ctrl;

  localparam int W  = 8;
  localparam int NS = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, start;
  logic [W-1:0] a, b;

  int n_checks = 0;
  int n_fail   = 0;

  serial_mag_comp_ctrl_if #(.WIDTH(W)) if0 ();
  serial_mag_comp_ctrl_if #(.WIDTH(W)) if1 ();

  assign if0.en = en;  assign if0.start = start;  assign if0.a = a;  assign if0.b = b;
  assign if1.en = en;  assign if1.start = start;  assign if1.a = a;  assign if1.b = b;

  serial_mag_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  serial_mag_comp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  always #5 clk = ~clk;

  // {busy, done, gtr, eq, lt}
  logic [4:0] o0, o1;
  assign o0 = {if0.busy, if0.done, if0.gtr, if0.eq, if0.lt};
  assign o1 = {if1.busy, if1.done, if1.gtr, if1.eq, if1.lt};

  // Reference model: outstanding cycles, pending and visible result per instance
  int         rem   [2];
  logic [2:0] pend  [2];
  logic [2:0] mres  [2];
  logic       mdone [2];

  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x > y)  return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Enabled cycles until done: early exit stops at the slice holding the top differing bit
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input int m);
    logic [W-1:0] d;
    int p;
    d = x ^ y;
    if (m == 1 || d == '0) return NS;
    p = 0;
    for (int i = 0; i < W; i++) if (d[i]) p = i;
    return NS - p / 2;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      rem[m] = 0; pend[m] = 3'b000; mres[m] = 3'b000; mdone[m] = 1'b0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (en) begin
      for (int m = 0; m < 2; m++) begin
        mdone[m] = 1'b0;
        if (rem[m] > 0) begin
          rem[m]--;
          if (rem[m] == 0) begin
            mdone[m] = 1'b1;
            mres[m]  = pend[m];
          end
        end else if (start) begin
          pend[m] = ref_res(a, b);
          rem[m]  = ref_lat(a, b, m);
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [4:0] o;
    for (int m = 0; m < 2; m++) begin
      o = (m == 0) ? o0 : o1;
      check($sformatf("busy%0d", m), 32'(o[4]), 32'(rem[m] > 0));
      check($sformatf("done%0d", m), 32'(o[3]), 32'(mdone[m]));
      check($sformatf("res%0d", m),  32'(o[2:0]), 32'(mres[m]));
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  // Launch one op and measure latency/result of both instances
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        output int lat0, output int lat1,
                        output logic [2:0] r0, output logic [2:0] r1);
    a = ta; b = tb_v; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    lat0 = 0; lat1 = 0; r0 = 3'b000; r1 = 3'b000;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (o0[3] && lat0 == 0) begin lat0 = c; r0 = o0[2:0]; end
      if (o1[3] && lat1 == 0) begin lat1 = c; r1 = o1[2:0]; end
      if (lat0 != 0 && lat1 != 0) break;
    end
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [2:0]   res;
    int           lat_ee;
    int           lat_full;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int         l0, l1, cyc, ndone;
    logic [2:0] r0, r1;

    vecs[0] = '{8'hA5, 8'hA5, 3'b010, 4, 4};
    vecs[1] = '{8'hC0, 8'h40, 3'b100, 1, 4};
    vecs[2] = '{8'h12, 8'h13, 3'b001, 4, 4};
    vecs[3] = '{8'hFF, 8'h00, 3'b100, 1, 4};
    vecs[4] = '{8'h00, 8'hFF, 3'b001, 1, 4};
    vecs[5] = '{8'h34, 8'h38, 3'b001, 3, 4};
    vecs[6] = '{8'h80, 8'h7F, 3'b100, 1, 4};
    vecs[7] = '{8'h00, 8'h00, 3'b010, 4, 4};
    vecs[8] = '{8'h0C, 8'h08, 3'b100, 3, 4};

    rst = 1'b1; en = 1'b0; start = 1'b0; a = '0; b = '0;
    model_reset();
    #1;
    check("reset_out0", 32'(o0), 32'h0);
    check("reset_out1", 32'(o1), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Table-driven vectors, issued back to back
    foreach (vecs[i]) begin
      run_op(vecs[i].va, vecs[i].vb, l0, l1, r0, r1);
      check($sformatf("vec%0d_lat_ee", i),   32'(l0), 32'(vecs[i].lat_ee));
      check($sformatf("vec%0d_lat_full", i), 32'(l1), 32'(vecs[i].lat_full));
      check($sformatf("vec%0d_res_ee", i),   32'(r0), 32'(vecs[i].res));
      check($sformatf("vec%0d_res_full", i), 32'(r1), 32'(vecs[i].res));
    end

    // Start accepted in the done cycle
    run_op(8'h12, 8'h13, l0, l1, r0, r1);
    check("b2b_first_res", 32'(r0), 32'(3'b001));
    run_op(8'hFF, 8'h00, l0, l1, r0, r1);
    check("b2b_second_lat", 32'(l0), 32'd1);
    check("b2b_second_res", 32'(r0), 32'(3'b100));

    // Start while busy ignored, then two stall cycles mid-op
    a = 8'h12; b = 8'h13; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'h00; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0; en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    cyc = 4; l0 = 0;
    for (int c = 0; c < 12 && l0 == 0; c++) begin
      tick();
      cyc++;
      if (o0[3]) l0 = cyc;
    end
    check("stall_lat", 32'(l0), 32'd6);
    check("stall_res", 32'(o0[2:0]), 32'(3'b001));
    tick();

    // Asynchronous reset in the middle of an op
    a = 8'h12; b = 8'h13; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(o0[4]), 32'd0);
    check("arst_done", 32'(o0[3]), 32'd0);
    check("arst_res",  32'(o0[2:0]), 32'd0);
    check("arst_out1", 32'(o1), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    run_op(8'h01, 8'h01, l0, l1, r0, r1);
    check("post_rst_res", 32'(r0), 32'(3'b010));
    check("post_rst_lat", 32'(l0), 32'd4);

    // Randomized traffic with en gaps and sporadic start
    ndone = 0;
    for (int c = 0; c < 30000 && ndone < 1000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ W'(1 << $urandom_range(0, W - 1));
        default: b = W'($urandom);
      endcase
      tick();
      if (o0[3]) begin
        ndone++;
        check("rand_onehot", 32'($countones(o0[2:0])), 32'd1);
      end
    end
    check("rand_op_count", 32'(ndone >= 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
